// File: rtl/prog_timer_pkg.sv
// Shared encodings for the programmable timer: channel FSM states and channel modes.
package prog_timer_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ch_state_e;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/prog_timer_ch.sv
// One timer channel: start/stop control, down-counter with reload, tick/busy/done flags.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | counter parked; prescaler ticks ignored
// ST_RUN  | counting down on each pre_tick; expiry at cnt==0 emits a tick
module prog_timer_ch
    import prog_timer_pkg::*;
#(
    parameter int Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             pre_tick_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic             oneshot_i,
    input  logic [Width-1:0] kmax_i,
    output logic             tick_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [Width-1:0] count_o
);

    ch_state_e        state_q, state_d;
    logic [Width-1:0] cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic             done_q, done_d;
    logic             tick_q, tick_d;

    // Priority: stop > start > expiry > decrement.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        done_d  = done_q;
        tick_d  = 1'b0;
        if (stop_i) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else if (start_i) begin
            state_d = ST_RUN;
            cnt_d   = kmax_i;
            mode_d  = oneshot_i;
            done_d  = 1'b0;
        end else if (state_q == ST_RUN && pre_tick_i) begin
            if (cnt_q == '0) begin
                tick_d = 1'b1;
                if (mode_q == MODE_ONESHOT) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    // kmax is sampled live so a new value applies from the next reload.
                    cnt_d = kmax_i;
                end
            end else begin
                cnt_d = cnt_q - Width'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= MODE_PERIODIC;
            done_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            tick_q  <= tick_d;
        end
    end

    assign tick_o  = tick_q;
    assign busy_o  = (state_q == ST_RUN);
    assign done_o  = done_q;
    assign count_o = cnt_q;

endmodule

// File: rtl/prog_timer.sv
// Multi-channel programmable timer: shared free-running prescaler feeding NumCh
// independent periodic/one-shot down-counter channels.
module prog_timer
    import prog_timer_pkg::*;
#(
    parameter int Width    = 16,
    parameter int NumCh    = 2,
    parameter int PreWidth = 8
) (
    input  logic                   rst_i,
    input  logic                   clk_i,
    input  logic                   en_i,
    input  logic [PreWidth-1:0]    pre_i,
    input  logic [NumCh-1:0]       start_i,
    input  logic [NumCh-1:0]       stop_i,
    input  logic [NumCh-1:0]       oneshot_i,
    input  logic [NumCh*Width-1:0] kmax_i,
    output logic [NumCh-1:0]       tick_o,
    output logic [NumCh-1:0]       busy_o,
    output logic [NumCh-1:0]       done_o,
    output logic [NumCh*Width-1:0] count_o
);

    logic [PreWidth-1:0] pre_q, pre_d;
    logic                pre_tick;

    // The prescaler is not realigned on start; the first period may be short.
    assign pre_tick = en_i && (pre_q == '0);

    always_comb begin
        pre_d = pre_q;
        if (pre_tick) begin
            pre_d = pre_i;
        end else if (en_i) begin
            pre_d = pre_q - PreWidth'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    for (genvar c = 0; c < NumCh; c++) begin : g_ch
        prog_timer_ch #(
            .Width(Width)
        ) u_ch (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .pre_tick_i(pre_tick),
            .start_i   (start_i[c]),
            .stop_i    (stop_i[c]),
            .oneshot_i (oneshot_i[c]),
            .kmax_i    (kmax_i[c*Width +: Width]),
            .tick_o    (tick_o[c]),
            .busy_o    (busy_o[c]),
            .done_o    (done_o[c]),
            .count_o   (count_o[c*Width +: Width])
        );
    end

endmodule
